tabuleiro_matriz: RTL

Puzzle board register for the LED-matrix game, sitting directly upstream of the game control unit. It holds the on/off state of every cell, loads the current level's starting pattern while the controller asserts `zeraM`, and applies player moves Lights-Out style: the addressed cell and its orthogonal neighbours toggle. When the board becomes all-dark it raises `nivel_concluido` to the controller and holds it until the next load.

---
 rtl/tabuleiro_matriz.sv | 82 ++++++++
 1 files changed

// File: rtl/tabuleiro_matriz.sv
// tabuleiro_matriz: Lights-Out style LED board register with load, move application and solve detection.
module tabuleiro_matriz #(
    parameter int LINHAS  = 4,
    parameter int COLUNAS = 4,
    parameter int CEL     = LINHAS * COLUNAS
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           zeraM,
    input  logic [CEL-1:0] padrao_nivel,
    input  logic           jogada,
    input  logic [2:0]     jogada_linha,
    input  logic [2:0]     jogada_coluna,
    output logic [CEL-1:0] matriz,
    output logic           nivel_concluido,
    output logic           pronto,
    output logic [7:0]     db_jogadas,
    output logic [2:0]     db_estado
);
    typedef enum logic [2:0] {
        CARREGA   = 3'd0,
        AGUARDA   = 3'd1,
        APLICA    = 3'd2,
        VERIFICA  = 3'd3,
        CONCLUIDO = 3'd4
    } estado_t;

    estado_t        estado;
    logic [2:0]     linhaR;
    logic [2:0]     colunaR;
    logic [CEL-1:0] mascara;
    logic           coordValida;

    assign coordValida = (32'(jogada_linha) < LINHAS) && (32'(jogada_coluna) < COLUNAS);
    assign pronto      = estado == AGUARDA;
    assign db_estado   = estado;

    // A cell is in the mask when its Manhattan distance to the move is at most 1; edges never wrap.
    always_comb begin
        mascara = '0;
        for (int l = 0; l < LINHAS; l++)
            for (int c = 0; c < COLUNAS; c++)
                mascara[l*COLUNAS+c] = ((l - int'(linhaR)) * (l - int'(linhaR)) +
                                        (c - int'(colunaR)) * (c - int'(colunaR))) <= 1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado          <= CARREGA;
            matriz          <= '0;
            nivel_concluido <= 1'b0;
            db_jogadas      <= '0;
            linhaR          <= '0;
            colunaR         <= '0;
        end else if (zeraM) begin
            estado          <= CARREGA;
            matriz          <= padrao_nivel;
            nivel_concluido <= 1'b0;
            db_jogadas      <= '0;
        end else begin
            case (estado)
                CARREGA: estado <= AGUARDA;
                AGUARDA: if (jogada && coordValida) begin
                    linhaR  <= jogada_linha;
                    colunaR <= jogada_coluna;
                    estado  <= APLICA;
                end
                APLICA: begin
                    matriz     <= matriz ^ mascara;
                    db_jogadas <= (db_jogadas == 8'hFF) ? db_jogadas : db_jogadas + 8'd1;
                    estado     <= VERIFICA;
                end
                VERIFICA: begin
                    nivel_concluido <= matriz == '0;
                    estado          <= (matriz == '0) ? CONCLUIDO : AGUARDA;
                end
                CONCLUIDO: nivel_concluido <= 1'b1;
                default: estado <= CARREGA;
            endcase
        end
    end
endmodule
